// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
//   Shared constants for the multi-hart run-control block:
//     - bit positions of the dmcontrol fields decoded from DMI writes
//     - bit positions inside the 12-bit status_o vector (dmstatus[19:8])
//     - reset value of status_o
//     - encoding of the per-hart resume FSM state
// -----------------------------------------------------------------------------
package jtag_pkg;

    // dmcontrol field positions
    localparam int HALTREQ      = 31;
    localparam int RESUMEREQ    = 30;
    localparam int ACKHAVERESET = 28;
    localparam int HASEL        = 26;
    localparam int HARTSEL_LO   = 16;
    localparam int NDMRESET     = 1;
    localparam int DMACTIVE     = 0;

    // status_o bit positions (dmstatus bit minus 8)
    localparam int ST_ANYHALTED       = 0;
    localparam int ST_ALLHALTED       = 1;
    localparam int ST_ANYRUNNING      = 2;
    localparam int ST_ALLRUNNING      = 3;
    localparam int ST_ANYUNAVAIL      = 4;
    localparam int ST_ALLUNAVAIL      = 5;
    localparam int ST_ANYNONEXISTENT  = 6;
    localparam int ST_ALLNONEXISTENT  = 7;
    localparam int ST_ANYRESUMEACK    = 8;
    localparam int ST_ALLRESUMEACK    = 9;
    localparam int ST_ANYHAVERESET    = 10;
    localparam int ST_ALLHAVERESET    = 11;

    // Every hart comes out of reset with havereset set.
    localparam logic [11:0] STATUS_RST = 12'b1100_0000_0000;

    // Resume FSM state encoding
    typedef logic [0:0] res_state_t;
    localparam res_state_t RES_IDLE = 1'b0;
    localparam res_state_t RES_REQ  = 1'b1;

endpackage

// File: rtl/jtag_hart_resume.sv
// -----------------------------------------------------------------------------
// jtag_hart_resume
//   Resume handshake for a single hart plus its resumeack flag.
//   IDLE -> REQ on go_i (the caller only raises go_i for a halted, selected hart
//   on a valid resume write). REQ -> IDLE once the hart is seen running, which
//   also sets resumeack. A new go_i while in REQ is ignored.
//
// Ports:
//   clk_i         core clock
//   rst_ni        asynchronous active-low reset (FSM to IDLE, ack cleared)
//   clear_i       synchronous soft reset (dmactive low): IDLE, ack cleared
//   go_i          start a resume request
//   halted_i      hart halted level
//   resume_req_o  resume request level to the hart
//   resumeack_o   resume acknowledged flag
// -----------------------------------------------------------------------------
module jtag_hart_resume
    import jtag_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic go_i,
    input  logic halted_i,
    output logic resume_req_o,
    output logic resumeack_o
);

    res_state_t state_q, state_d;
    logic       ack_q, ack_d;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        if (clear_i) begin
            state_d = RES_IDLE;
            ack_d   = 1'b0;
        end else if (state_q == RES_IDLE) begin
            if (go_i) begin
                state_d = RES_REQ;
                ack_d   = 1'b0;
            end
        end else begin
            if (!halted_i) begin
                state_d = RES_IDLE;
                ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RES_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Driven straight from the state flop so an async reset drops it at once.
    assign resume_req_o = (state_q == RES_REQ);
    assign resumeack_o  = ack_q;

endmodule

// File: rtl/jtag_hart_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_hart_ctrl
//   Multi-hart run control for the debug module (core clock domain, after the
//   DMI crossing). Decodes dmcontrol writes into per-hart halt/resume requests,
//   tracks resumeack/havereset per hart and builds the dmstatus hart summary.
//
// Configuration:
//   JTAG_HART_ARRAY_EN  when defined, the hart array mask (hawindow) and hasel
//                       are implemented; otherwise hawindow_* is ignored, hasel
//                       reads 0 and only the hartsel hart is ever selected.
//
// Parameters:
//   NUM_HARTS  number of harts (1..32)
//   HARTSEL_W  width of the hartsel field
//
// Ports:
//   clk_i, rst_ni      core clock, asynchronous active-low reset
//   dmctrl_we_i        one-cycle dmcontrol write strobe
//   dmctrl_wdata_i     dmcontrol write data
//   hawindow_we_i      hart array mask write strobe
//   hawindow_wdata_i   hart array mask (bit h selects hart h)
//   halted_i           per-hart halted level
//   hart_reset_i       per-hart reset-active level
//   dmctrl_o           dmcontrol readback (resumereq/ackhavereset read 0)
//   status_o           dmstatus[19:8], registered
//   debug_req_o        per-hart halt request
//   resume_req_o       per-hart resume request
//   ndmreset_o         non-debug-module reset request
// -----------------------------------------------------------------------------
module jtag_hart_ctrl
    import jtag_pkg::*;
#(
    parameter int NUM_HARTS = 4,
    parameter int HARTSEL_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dmctrl_we_i,
    input  logic [31:0]          dmctrl_wdata_i,
    input  logic                 hawindow_we_i,
    input  logic [31:0]          hawindow_wdata_i,
    input  logic [NUM_HARTS-1:0] halted_i,
    input  logic [NUM_HARTS-1:0] hart_reset_i,
    output logic [31:0]          dmctrl_o,
    output logic [11:0]          status_o,
    output logic [NUM_HARTS-1:0] debug_req_o,
    output logic [NUM_HARTS-1:0] resume_req_o,
    output logic                 ndmreset_o
);

    localparam logic [HARTSEL_W-1:0] HARTS_LIMIT = HARTSEL_W'(NUM_HARTS);

    logic [NUM_HARTS-1:0] haltreq_q, haltreq_d;
    logic [NUM_HARTS-1:0] havereset_q, havereset_d;
    logic [HARTSEL_W-1:0] hartsel_q, hartsel_d;
    logic                 ndmreset_q, ndmreset_d;
    logic                 dmactive_q, dmactive_d;
    logic [11:0]          status_q, status_d;

    logic [HARTSEL_W-1:0] wr_hartsel;
    logic                 wr_en;
    logic                 soft_clr;
    logic [NUM_HARTS-1:0] sel_wr;
    logic [NUM_HARTS-1:0] sel_cur;
    logic [NUM_HARTS-1:0] resume_go;
    logic [NUM_HARTS-1:0] resumeack;
    logic                 nonexist;

    // Array-select state: real registers or tied off, depending on the build.
    logic                 hasel;
    logic                 wr_hasel;
    logic [NUM_HARTS-1:0] hawindow;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [NUM_HARTS-1:0] select_harts(
        input logic [HARTSEL_W-1:0] hs,
        input logic                 hs_array,
        input logic [NUM_HARTS-1:0] win
    );
        logic [NUM_HARTS-1:0] s;
        s = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            // An out-of-range hartsel never matches any index, so it simply
            // contributes no hart.
            if (hs == HARTSEL_W'(h)) s[h] = 1'b1;
            if (hs_array && win[h]) s[h] = 1'b1;
        end
        return s;
    endfunction

    // "all" flags are false whenever a nonexistent hart is part of the
    // selection, and for an empty selection.
    function automatic logic all_of(
        input logic [NUM_HARTS-1:0] s,
        input logic [NUM_HARTS-1:0] f,
        input logic                 nx
    );
        return !nx && (s != '0) && ((s & ~f) == '0);
    endfunction

    // -------------------------------------------------------------------------
    // Write decode
    // -------------------------------------------------------------------------
    assign wr_hartsel = dmctrl_wdata_i[HARTSEL_LO +: HARTSEL_W];

    // While inactive only a write that sets dmactive is accepted.
    assign wr_en = dmctrl_we_i && (dmactive_q || dmctrl_wdata_i[DMACTIVE]);

    always_comb begin
        dmactive_d = dmactive_q;
        if (wr_en) dmactive_d = dmctrl_wdata_i[DMACTIVE];
    end

    // Soft reset follows the dmactive value being latched this cycle, so a
    // deactivating write takes effect on the same edge that stores it.
    assign soft_clr = !dmactive_d;

`ifdef JTAG_HART_ARRAY_EN
    logic                 hasel_q, hasel_d;
    logic [NUM_HARTS-1:0] hawindow_q, hawindow_d;

    assign wr_hasel = dmctrl_wdata_i[HASEL];

    always_comb begin
        hasel_d    = hasel_q;
        hawindow_d = hawindow_q;
        if (wr_en) hasel_d = wr_hasel;
        // The mask update lands after the same-cycle dmcontrol write, which
        // therefore still uses the old mask (sel_wr reads hawindow_q).
        if (hawindow_we_i) hawindow_d = hawindow_wdata_i[NUM_HARTS-1:0];
        if (soft_clr) begin
            hasel_d    = 1'b0;
            hawindow_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hasel_q    <= 1'b0;
            hawindow_q <= '0;
        end else begin
            hasel_q    <= hasel_d;
            hawindow_q <= hawindow_d;
        end
    end

    assign hasel    = hasel_q;
    assign hawindow = hawindow_q;

    logic unused_hawindow;
    assign unused_hawindow = ^hawindow_wdata_i;
`else
    assign wr_hasel = 1'b0;
    assign hasel    = 1'b0;
    assign hawindow = '0;

    logic unused_hawindow;
    assign unused_hawindow = ^{hawindow_we_i, hawindow_wdata_i};
`endif

    // Fields of dmcontrol that this block does not decode.
    logic unused_wdata;
    assign unused_wdata = ^dmctrl_wdata_i;

    assign sel_wr  = select_harts(wr_hartsel, wr_hasel, hawindow);
    assign sel_cur = select_harts(hartsel_q, hasel, hawindow);

    // -------------------------------------------------------------------------
    // Next-state for halt requests, hartsel, ndmreset and havereset
    // -------------------------------------------------------------------------
    always_comb begin
        haltreq_d   = haltreq_q;
        hartsel_d   = hartsel_q;
        ndmreset_d  = ndmreset_q;
        havereset_d = havereset_q;

        if (wr_en) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (sel_wr[h]) haltreq_d[h] = dmctrl_wdata_i[HALTREQ];
            end
            hartsel_d  = wr_hartsel;
            ndmreset_d = dmctrl_wdata_i[NDMRESET];
            if (dmctrl_wdata_i[ACKHAVERESET]) havereset_d = havereset_d & ~sel_wr;
        end

        // Reset activity wins over an acknowledge in the same cycle.
        havereset_d = havereset_d | hart_reset_i;

        // havereset deliberately survives the soft reset.
        if (soft_clr) begin
            haltreq_d  = '0;
            hartsel_d  = '0;
            ndmreset_d = 1'b0;
        end
    end

    // A resume write combined with haltreq is ignored; running harts are
    // never asked to resume.
    always_comb begin
        resume_go = '0;
        if (wr_en && dmctrl_wdata_i[RESUMEREQ] && !dmctrl_wdata_i[HALTREQ]) begin
            resume_go = sel_wr & halted_i;
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        jtag_hart_resume u_resume (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .clear_i      (soft_clr),
            .go_i         (resume_go[h]),
            .halted_i     (halted_i[h]),
            .resume_req_o (resume_req_o[h]),
            .resumeack_o  (resumeack[h])
        );
    end

    // -------------------------------------------------------------------------
    // Hart summary over the current selection
    // -------------------------------------------------------------------------
    assign nonexist = (hartsel_q >= HARTS_LIMIT);

    always_comb begin
        logic [NUM_HARTS-1:0] running;
        running  = ~halted_i & ~hart_reset_i;
        status_d = '0;
        status_d[ST_ALLHAVERESET]   = all_of(sel_cur, havereset_q, nonexist);
        status_d[ST_ANYHAVERESET]   = |(sel_cur & havereset_q);
        status_d[ST_ALLRESUMEACK]   = all_of(sel_cur, resumeack, nonexist);
        status_d[ST_ANYRESUMEACK]   = |(sel_cur & resumeack);
        status_d[ST_ALLNONEXISTENT] = nonexist && (sel_cur == '0);
        status_d[ST_ANYNONEXISTENT] = nonexist;
        status_d[ST_ALLUNAVAIL]     = all_of(sel_cur, hart_reset_i, nonexist);
        status_d[ST_ANYUNAVAIL]     = |(sel_cur & hart_reset_i);
        status_d[ST_ALLRUNNING]     = all_of(sel_cur, running, nonexist);
        status_d[ST_ANYRUNNING]     = |(sel_cur & running);
        status_d[ST_ALLHALTED]      = all_of(sel_cur, halted_i, nonexist);
        status_d[ST_ANYHALTED]      = |(sel_cur & halted_i);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            haltreq_q   <= '0;
            havereset_q <= '1;
            hartsel_q   <= '0;
            ndmreset_q  <= 1'b0;
            dmactive_q  <= 1'b0;
            status_q    <= STATUS_RST;
        end else begin
            haltreq_q   <= haltreq_d;
            havereset_q <= havereset_d;
            hartsel_q   <= hartsel_d;
            ndmreset_q  <= ndmreset_d;
            dmactive_q  <= dmactive_d;
            status_q    <= status_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // haltreq reads back as set when any currently selected hart has it set.
    always_comb begin
        dmctrl_o                            = '0;
        dmctrl_o[HALTREQ]                   = |(haltreq_q & sel_cur);
        dmctrl_o[HASEL]                     = hasel;
        dmctrl_o[HARTSEL_LO +: HARTSEL_W]   = hartsel_q;
        dmctrl_o[NDMRESET]                  = ndmreset_q;
        dmctrl_o[DMACTIVE]                  = dmactive_q;
    end

    assign status_o    = status_q;
    assign debug_req_o = haltreq_q;
    assign ndmreset_o  = ndmreset_q;

endmodule

// File: doc/jtag_hart_ctrl.md
Name: jtag_hart_ctrl

Overview:
- Multi-hart run-control block for the debug module, generalising single-hart debug_req/halted handling to NUM_HARTS harts.
- Decodes dmcontrol writes from the DMI side and drives per-hart halt and resume requests.
- Tracks the per-hart resumeack and havereset flags and produces the aggregated dmstatus hart-summary bits.
- Sits between the DM register file and the harts, in the core clock domain after the DMI clock-domain crossing.

Parameters:
- NUM_HARTS, 4, number of harts controlled; range 1..32.
- HARTSEL_W, 10, width of the hartsel field (hartsello).

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- dmctrl_we_i  in  1  one-cycle write strobe for dmcontrol.
- dmctrl_wdata_i  in  32  dmcontrol write data. Field bits: 31 haltreq, 30 resumereq, 28 ackhavereset, 26 hasel, 25:16 hartsel, 1 ndmreset, 0 dmactive.
- hawindow_we_i  in  1  write strobe for the hart array mask.
- hawindow_wdata_i  in  32  hart array mask; bit h selects hart h.
- halted_i  in  NUM_HARTS  per-hart halted level from the core.
- hart_reset_i  in  NUM_HARTS  per-hart reset-active level.
- dmctrl_o  out  32  dmcontrol readback. resumereq and ackhavereset read as 0.
- status_o  out  12  dmstatus bits [19:8], MSB first: allhavereset, anyhavereset, allresumeack, anyresumeack, allnonexistent, anynonexistent, allunavail, anyunavail, allrunning, anyrunning, allhalted, anyhalted.
- debug_req_o  out  NUM_HARTS  per-hart halt request (level).
- resume_req_o  out  NUM_HARTS  per-hart resume request (level).
- ndmreset_o  out  1  non-debug-module reset request.

Behaviour:
- Reset values:
  - All outputs 0, except status_o = 12'b110000000000 (every hart has havereset set).
  - haltreq, hartsel, hasel, hawindow, ndmreset and dmactive registers cleared.
  - havereset[] set to all ones; resumeack[] cleared.
- Selection set sel[h]:
  - h == hartsel and hartsel < NUM_HARTS; OR
  - hasel == 1 and hawindow[h] == 1.
  - hartsel >= NUM_HARTS selects no hart via hartsel and marks a nonexistent selection.
- dmctrl write handling:
  - hartsel, hasel, ndmreset and dmactive are latched on every dmctrl_we_i.
  - The selection for that write's actions uses the newly written hartsel/hasel.
- haltreq:
  - On a write, haltreq[h] <= wdata[31] for every selected h; unselected harts are unchanged.
  - debug_req_o[h] = haltreq[h], registered, so it is asserted 1 cycle after the strobe.
- Resume, per-hart FSM with states IDLE and REQ:
  - IDLE->REQ when: write with resumereq=1 and haltreq=0, sel[h], and halted_i[h]=1. On entry: resumeack[h]<=0, resume_req_o[h]<=1.
  - resumereq together with haltreq=1 is ignored.
  - resumereq to a running hart is ignored and resumeack is unchanged.
  - REQ->IDLE when halted_i[h]==0 is sampled: resumeack[h]<=1, resume_req_o[h]<=0.
  - A new resumereq while in REQ is ignored.
- havereset:
  - Set while hart_reset_i[h]=1.
  - Cleared by a write with ackhavereset=1 for selected h.
  - Set has priority over clear in the same cycle.
- ndmreset_o = latched ndmreset bit, 1 cycle after the write.
- dmactive=0 (latched) acts as a synchronous soft reset:
  - haltreq, hawindow, hartsel and hasel are cleared; all resume FSMs go to IDLE; resumeack is cleared; ndmreset_o is driven 0.
  - havereset is preserved.
  - Writes other than dmactive=1 are ignored while inactive.
- status_o: registered, 1-cycle latency, computed over the selected harts.
  - Empty selection with hartsel >= NUM_HARTS: allnonexistent = anynonexistent = 1; every "all" flag other than allnonexistent is 0.
  - anynonexistent = 1 whenever hartsel >= NUM_HARTS, even if hasel adds harts.
  - unavail[h] = hart_reset_i[h].
  - running = !halted && !unavail.
- Simultaneous events: a hawindow write in the same cycle as a dmctrl write takes effect after the dmctrl write is processed. The old mask applies to that dmctrl write.
- Asynchronous reset mid-resume: the FSM returns to IDLE and resume_req_o drops immediately.

Optional Feature:
- Macro JTAG_HART_ARRAY_EN.
- Defined: the hawindow register and hasel are implemented as specified.
- Undefined: hawindow_* inputs are ignored, hasel reads 0, and the selection set is the hartsel hart only.

Decomposition:
- Package jtag_pkg holds:
  - dmcontrol bit-position constants (HALTREQ=31, RESUMEREQ=30, ACKHAVERESET=28, HASEL=26, HARTSEL_LO=16, NDMRESET=1, DMACTIVE=0);
  - the status_o index constants;
  - the resume FSM state typedef (IDLE, REQ).
- Sub-module jtag_hart_resume: one resume FSM plus its resumeack flag, instantiated NUM_HARTS times by a generate loop.

Test Plan:
- Reset, then write 0x00000001 (dmactive), then 0x80000001 (haltreq, hartsel 0) -> debug_req_o=4'b0001 one cycle later. Raise halted_i[0] -> anyhalted=1, allhalted=1.
- Hart 0 halted, write 0x40000001 -> resume_req_o[0]=1 and resumeack[0]=0. Drop halted_i[0] -> resume_req_o[0]=0 the next cycle; allresumeack=1.
- Write hartsel=7 (0x00070001) with NUM_HARTS=4 -> status_o allnonexistent=1, anynonexistent=1, and all other "all" flags 0.
- After reset, all havereset flags set. Write 0x10000001 (ackhavereset, hart 0) -> anyhavereset stays 1 with hartsel 1. Select hart 0 -> havereset clear for hart 0.
- With JTAG_HART_ARRAY_EN: hawindow=0xA, then write 0x84000001 (haltreq, hasel) -> debug_req_o=4'b1011. Halt harts 1 and 3 only -> anyhalted=1, allhalted=0.
- Mid-resume (resume_req_o[2]=1), write 0x00000000 (dmactive=0) -> resume_req_o=0, debug_req_o=0, ndmreset_o=0; havereset retained.
